// File: rtl/register_file_pkg.sv
// Shared constants for the rename-aware architectural register file.
// These constants take the place of the REG_NUM / ROB_INDEX_BIT entries in const.v.
package register_file_pkg;

    localparam int DEF_REG_NUM       = 32;
    localparam int DEF_XLEN          = 32;
    localparam int DEF_ROB_INDEX_BIT = 4;
    localparam int REG_IDX_BIT       = 5;

endpackage

// File: rtl/register_file_rf_read_port.sv
// Combinational operand lookup: returns a register's value, or the ROB id of its producer.
// A tag-matching commit in the current cycle is forwarded so that dispatch sees the value immediately.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int REG_NUM       = DEF_REG_NUM,
    parameter int XLEN          = DEF_XLEN,
    parameter int ROB_INDEX_BIT = DEF_ROB_INDEX_BIT
) (
    input  logic [REG_IDX_BIT-1:0]   rs,
    input  logic [XLEN-1:0]          reg_val  [REG_NUM],
    input  logic                     reg_busy [REG_NUM],
    input  logic [ROB_INDEX_BIT-1:0] reg_tag  [REG_NUM],
    input  logic                     commit_en,
    input  logic [REG_IDX_BIT-1:0]   commit_rd,
    input  logic [XLEN-1:0]          commit_val,
    input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    output logic [XLEN-1:0]          val,
    output logic                     busy,
    output logic [ROB_INDEX_BIT-1:0] rob_id
);

    always_comb begin
        val    = '0;
        busy   = 1'b0;
        rob_id = '0;
        if (rs != '0) begin
            val    = reg_val[rs];
            busy   = reg_busy[rs];
            rob_id = reg_tag[rs];
            // The producer is retiring this cycle, so its value can be forwarded.
            if (reg_busy[rs] && commit_en && commit_rd == rs && reg_tag[rs] == commit_rob_id) begin
                busy = 1'b0;
                val  = commit_val;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags. Issue marks registers busy, and ROB commit
// writes back values and releases the tags. Two combinational operand read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int REG_NUM       = DEF_REG_NUM,
    parameter int XLEN          = DEF_XLEN,
    parameter int ROB_INDEX_BIT = DEF_ROB_INDEX_BIT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     issue_req,
    input  logic [REG_IDX_BIT-1:0]   issue_rd,
    input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic [REG_IDX_BIT-1:0]   commit_rd,
    input  logic [XLEN-1:0]          commit_val,
    input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    input  logic [REG_IDX_BIT-1:0]   rs1_in,
    output logic [XLEN-1:0]          rs1_val,
    output logic                     rs1_busy,
    output logic [ROB_INDEX_BIT-1:0] rs1_rob_id,
    input  logic [REG_IDX_BIT-1:0]   rs2_in,
    output logic [XLEN-1:0]          rs2_val,
    output logic                     rs2_busy,
    output logic [ROB_INDEX_BIT-1:0] rs2_rob_id
);

    logic [XLEN-1:0]          reg_val  [REG_NUM];
    logic                     reg_busy [REG_NUM];
    logic [ROB_INDEX_BIT-1:0] reg_tag  [REG_NUM];

    logic commit_en;
    logic commit_hit;
    logic issue_en;

    assign commit_en  = rdy_in && (commit_rd != '0);
    assign commit_hit = reg_busy[commit_rd] && (reg_tag[commit_rd] == commit_rob_id);
    assign issue_en   = issue_req && (issue_rd != '0);

    // x0 is never written after reset, so it stays at value 0 and is never busy.
    // Within the else branch, the later issue assignment overrides the commit release of busy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                reg_val[i]  <= '0;
                reg_busy[i] <= 1'b0;
                reg_tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                reg_val[commit_rd] <= commit_val;
            end
            if (clear_in) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    reg_busy[i] <= 1'b0;
                    reg_tag[i]  <= '0;
                end
            end else begin
                if (commit_en && commit_hit) begin
                    reg_busy[commit_rd] <= 1'b0;
                end
                if (issue_en) begin
                    reg_busy[issue_rd] <= 1'b1;
                    reg_tag[issue_rd]  <= issue_rob_id;
                end
            end
        end
    end

    rf_read_port #(
        .REG_NUM      (REG_NUM),
        .XLEN         (XLEN),
        .ROB_INDEX_BIT(ROB_INDEX_BIT)
    ) u_read_rs1 (
        .rs           (rs1_in),
        .reg_val      (reg_val),
        .reg_busy     (reg_busy),
        .reg_tag      (reg_tag),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_rob_id(commit_rob_id),
        .val          (rs1_val),
        .busy         (rs1_busy),
        .rob_id       (rs1_rob_id)
    );

    rf_read_port #(
        .REG_NUM      (REG_NUM),
        .XLEN         (XLEN),
        .ROB_INDEX_BIT(ROB_INDEX_BIT)
    ) u_read_rs2 (
        .rs           (rs2_in),
        .reg_val      (reg_val),
        .reg_busy     (reg_busy),
        .reg_tag      (reg_tag),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_rob_id(commit_rob_id),
        .val          (rs2_val),
        .busy         (rs2_busy),
        .rob_id       (rs2_rob_id)
    );

endmodule
